// File: rtl/boot_fetch_pkg.sv
// Shared types and default widths for the boot loader / fetch unit.
// No logic and no latency; this package only declares the FSM state
// encoding and the default word and address widths.
package boot_fetch_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_pc.sv
// Program counter with redirect, stall and increment logic.
// Latency: the PC updates on the clock edge after en_i/stall_i/redirect_i are sampled.
// Backpressure: stall_i holds the PC. redirect_i wins over stall_i. Nothing moves while en_i is low.
module fetch_pc #(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en_i,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_inc_o
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0] pc_q, pc_d;

    // Sum is truncated to ADDR_W bits, so the PC wraps modulo 2^ADDR_W.
    assign pc_inc_o = pc_q + STEP;
    assign pc_o     = pc_q;

    // Next PC: redirect has priority, then stall holds, otherwise advance.
    always_comb begin
        pc_d = pc_q;
        if (en_i) begin
            if (redirect_i)    pc_d = redirect_pc_i;
            else if (!stall_i) pc_d = pc_inc_o;
        end
    end

    // PC register.
    always_ff @(posedge clock) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

endmodule

// File: rtl/boot_fetch_unit.sv
// Boot loader that copies BOOT_WORDS words into instruction memory, then runs the instruction fetch stage.
// Latency: each boot word is written in the cycle it is offered. Fetch has 1 cycle from PC to the IF/ID register.
// Backpressure: boot_ready is high for the whole load. stall holds the PC and IF/ID. Option BOOT_CHECKSUM_EN validates the image sum.
module boot_fetch_unit
    import boot_fetch_pkg::*;
#(
    parameter int          DATA_W     = DEF_DATA_W,
    parameter int          ADDR_W     = DEF_ADDR_W,
    parameter int          BOOT_WORDS = 16,
    parameter int unsigned RESET_PC   = 0,
    parameter int          PC_STEP    = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] boot_data,
    input  logic              boot_valid,
    output logic              boot_ready,
    input  logic [DATA_W-1:0] boot_checksum,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              imem_we,
    output logic              imem_oe,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_id_valid,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0] if_id_pcpp,
    output logic              on_bios,
    output logic              boot_error
);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(BOOT_WORDS - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              if_id_valid_q;
    logic [DATA_W-1:0] if_id_instr_q;
    logic [ADDR_W-1:0] if_id_pcpp_q;
    logic [ADDR_W-1:0] pc, pc_inc;
    logic              run, boot_hs, sum_ok;

    assign run     = (state_q == ST_RUN);
    assign boot_hs = (state_q == ST_BOOT) && boot_valid;

`ifdef BOOT_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;
    logic              boot_error_q;
    // The final word is folded in before the compare.
    assign sum_ok     = ((sum_q + boot_data) == boot_checksum);
    assign boot_error = boot_error_q;
`else
    logic unused_checksum;
    assign unused_checksum = ^boot_checksum;
    assign sum_ok          = 1'b1;
    assign boot_error      = 1'b0;
`endif

    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (ADDR_W'(RESET_PC)),
        .PC_STEP  (PC_STEP)
    ) u_fetch_pc (
        .clock         (clock),
        .reset         (reset),
        .en_i          (run),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .pc_o          (pc),
        .pc_inc_o      (pc_inc)
    );

    // Memory-port and status decode from the current state. During reset no boot write is accepted.
    always_comb begin
        boot_ready = 1'b0;
        on_bios    = 1'b0;
        imem_we    = 1'b0;
        imem_oe    = 1'b0;
        imem_addr  = pc;
        imem_wdata = boot_data;
        case (state_q)
            ST_BOOT: begin
                boot_ready = !reset;
                on_bios    = 1'b1;
                imem_addr  = cnt_q;
                imem_we    = boot_valid && !reset;
            end
            ST_RUN:  imem_oe = 1'b1;
            default: ;
        endcase
    end

    // Sequencer: loads the boot image, then drives the IF/ID register while in run.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            cnt_q         <= '0;
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= '0;
            if_id_pcpp_q  <= '0;
`ifdef BOOT_CHECKSUM_EN
            sum_q         <= '0;
            boot_error_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_BOOT: begin
                    if (boot_hs) begin
                        cnt_q <= cnt_q + ADDR_W'(1);
`ifdef BOOT_CHECKSUM_EN
                        sum_q <= sum_q + boot_data;
`endif
                        if (cnt_q == LAST_WORD) begin
                            if (sum_ok) begin
                                state_q <= ST_RUN;
                            end else begin
                                state_q <= ST_ERROR;
`ifdef BOOT_CHECKSUM_EN
                                boot_error_q <= 1'b1;
`endif
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (redirect) begin
                        if_id_valid_q <= 1'b0;
                    end else if (!stall) begin
                        if_id_valid_q <= 1'b1;
                        if_id_instr_q <= imem_rdata;
                        if_id_pcpp_q  <= pc_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_id_valid = if_id_valid_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pcpp  = if_id_pcpp_q;

endmodule

// File: tb/tb_boot_fetch_unit.sv
// Directed bench for boot_fetch_unit with BOOT_WORDS=4, RESET_PC=0 and PC_STEP=1.
// A small memory model records the boot writes and returns the fetched words.
// All checks go through chk(). Expected values are written out by hand.
module tb_boot_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] boot_data;
    logic        boot_valid;
    logic        boot_ready;
    logic [31:0] boot_checksum;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_we;
    logic        imem_oe;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pcpp;
    logic        on_bios;
    logic        boot_error;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int w0;

    logic [31:0] img [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    logic [31:0] mem [16];

    always #5 clock = ~clock;

    boot_fetch_unit #(
        .DATA_W     (32),
        .ADDR_W     (32),
        .BOOT_WORDS (4),
        .RESET_PC   (0),
        .PC_STEP    (1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .boot_data     (boot_data),
        .boot_valid    (boot_valid),
        .boot_ready    (boot_ready),
        .boot_checksum (boot_checksum),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .imem_we       (imem_we),
        .imem_oe       (imem_oe),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pcpp    (if_id_pcpp),
        .on_bios       (on_bios),
        .boot_error    (boot_error)
    );

    // Instruction memory model: combinational read, write on the clock edge.
    assign imem_rdata = mem[imem_addr[3:0]];
    always @(posedge clock) begin
        if (imem_we) begin
            mem[imem_addr[3:0]] <= imem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer nwords image words and check each write in its own cycle.
    // With gaps set, one idle cycle comes before each word.
    task automatic boot(input bit gaps, input int nwords);
        for (int k = 0; k < nwords; k++) begin
            if (gaps) begin
                boot_valid = 1'b0;
                #1;
                chk("boot_idle_we", imem_we, 0);
                tick();
            end
            boot_valid = 1'b1;
            boot_data  = img[k];
            #1;
            chk("boot_we", imem_we, 1);
            chk("boot_addr", imem_addr, k);
            chk("boot_wdata", imem_wdata, img[k]);
            chk("boot_ready", boot_ready, 1);
            chk("boot_bios", on_bios, 1);
            chk("boot_oe", imem_oe, 0);
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        reset = 1'b1; boot_valid = 1'b1; boot_data = 32'h99;
        boot_checksum = 32'hAA; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        tick(); tick();
        // Checks taken while reset is still asserted.
        chk("rst_ready", boot_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_valid", if_id_valid, 0);
        chk("rst_instr", if_id_instr, 0);
        chk("rst_pcpp", if_id_pcpp, 0);
        chk("rst_err", boot_error, 0);

        // Back-to-back boot. boot_valid stays high into run to show it is ignored there.
        reset = 1'b0;
        w0 = wr_cnt;
        boot(1'b0, 4);
        chk("run_bios", on_bios, 0);
        chk("run_oe", imem_oe, 1);
        chk("run_we", imem_we, 0);
        chk("run_ready", boot_ready, 0);
        chk("run_pc0", imem_addr, 0);
        chk("run_valid0", if_id_valid, 0);
        chk("boot_wr_cnt", wr_cnt - w0, 4);
        for (int k = 0; k < 4; k++) chk("mem_img", mem[k], img[k]);
        boot_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("fetch_valid", if_id_valid, 1);
            chk("fetch_instr", if_id_instr, img[k]);
            chk("fetch_pcpp", if_id_pcpp, k + 1);
        end

        // Reload with idle gaps. stall and redirect are held during one boot cycle and must be ignored.
        reset = 1'b1; tick(); reset = 1'b0;
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h7;
        tick();
        chk("boot_ign_addr", imem_addr, 0);
        chk("boot_ign_bios", on_bios, 1);
        stall = 1'b0; redirect = 1'b0;
        w0 = wr_cnt;
        boot(1'b1, 4);
        boot_valid = 1'b0;
        chk("gap_wr_cnt", wr_cnt - w0, 4);
        chk("gap_run_pc", imem_addr, 0);
        chk("gap_run_bios", on_bios, 0);

        // Stall at PC=2 for two cycles, then redirect while stalled.
        tick();
        chk("sr_instr1", if_id_instr, 32'h11);
        tick();
        chk("sr_instr2", if_id_instr, 32'h22);
        chk("sr_pc2", imem_addr, 2);
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("stall_valid", if_id_valid, 1);
            chk("stall_instr", if_id_instr, 32'h22);
            chk("stall_pcpp", if_id_pcpp, 2);
            chk("stall_pc", imem_addr, 2);
        end
        redirect = 1'b1; redirect_pc = 32'h0;
        tick();
        chk("redir_valid", if_id_valid, 0);
        chk("redir_pc", imem_addr, 0);
        redirect = 1'b0; stall = 1'b0;
        tick();
        chk("redir_instr", if_id_instr, 32'h11);
        chk("redir_pcpp", if_id_pcpp, 1);
        chk("redir_valid1", if_id_valid, 1);

        // PC and if_id_pcpp wrap at the top of the address space.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        chk("wrap_pc", imem_addr, 32'hFFFF_FFFF);
        tick();
        chk("wrap_pcpp", if_id_pcpp, 0);
        chk("wrap_next_pc", imem_addr, 0);

        // Reset in the middle of a load restarts at word 0.
        reset = 1'b1; tick(); reset = 1'b0;
        boot(1'b0, 2);
        chk("mid_cnt2", imem_addr, 2);
        reset = 1'b1;
        #1;
        chk("mid_rst_we", imem_we, 0);
        chk("mid_rst_ready", boot_ready, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("mid_cnt0", imem_addr, 0);
        w0 = wr_cnt;
        boot(1'b0, 4);
        boot_valid = 1'b0;
        chk("mid_wr_cnt", wr_cnt - w0, 4);
        chk("mid_run_bios", on_bios, 0);

        // Boot with a wrong image sum.
        reset = 1'b1; tick(); reset = 1'b0;
        boot_checksum = 32'hAB;
        boot(1'b0, 4);
        boot_valid = 1'b1;
        #1;
`ifdef BOOT_CHECKSUM_EN
        chk("cs_err", boot_error, 1);
        chk("cs_oe", imem_oe, 0);
        chk("cs_ready", boot_ready, 0);
        chk("cs_bios", on_bios, 0);
        chk("cs_we", imem_we, 0);
        tick(); tick();
        chk("cs_valid", if_id_valid, 0);
        chk("cs_err_hold", boot_error, 1);
`else
        chk("nocs_err", boot_error, 0);
        chk("nocs_oe", imem_oe, 1);
        chk("nocs_bios", on_bios, 0);
        tick(); tick();
        chk("nocs_valid", if_id_valid, 1);
        chk("nocs_err_hold", boot_error, 0);
`endif
        boot_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/boot_fetch_unit.md
BOOT_FETCH_UNIT -- requirements
Module: boot_fetch_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: ports clock and reset; all state updates on posedge clock.
REQ-002 Parameters SHALL be:
- DATA_W, 32, instruction/data word width.
- ADDR_W, 32, instruction address width.
- BOOT_WORDS, 16, words copied by the boot loader (>=1).
- RESET_PC, 0, first fetch address after boot.
- PC_STEP, 1, PC increment (word addressing).
REQ-003 Ports SHALL be (name direction width meaning):
- clock in 1 system clock
- reset in 1 synchronous active-high reset
- boot_data in DATA_W boot image word
- boot_valid in 1 boot word offered
- boot_ready out 1 loader accepts word
- boot_checksum in DATA_W expected image sum (used only with checksum feature)
- imem_addr out ADDR_W instruction memory address
- imem_wdata out DATA_W memory write data
- imem_we out 1 memory write enable
- imem_oe out 1 memory output enable
- imem_rdata in DATA_W memory read data, combinational from imem_addr
- stall in 1 hold fetch and IF/ID
- redirect in 1 branch/jump taken
- redirect_pc in ADDR_W redirect target
- if_id_valid out 1 IF/ID slot holds a valid instruction
- if_id_instr out DATA_W fetched instruction
- if_id_pcpp out ADDR_W fetch address + PC_STEP
- on_bios out 1 boot load in progress
- boot_error out 1 boot image rejected

Function
REQ-004 FSM states SHALL be ST_BOOT, ST_RUN, ST_ERROR.
REQ-005 ST_BOOT: boot_ready=1, on_bios=1, imem_oe=0, imem_addr=load counter, imem_wdata=boot_data, imem_we=boot_valid (combinational, same cycle).
REQ-006 Each boot handshake (boot_valid & boot_ready) SHALL increment the load counter; the handshake with counter==BOOT_WORDS-1 moves the FSM to ST_RUN (or per REQ-016) on the next edge.
REQ-007 ST_RUN: boot_ready=0, on_bios=0, imem_we=0, imem_oe=1, imem_addr=PC; boot_valid ignored.
REQ-008 PC SHALL equal RESET_PC on the first ST_RUN cycle; the first if_id_valid=1 appears one cycle later (1-cycle fetch latency).
REQ-009 ST_RUN, no stall, no redirect: if_id_instr<=imem_rdata, if_id_pcpp<=PC+PC_STEP, if_id_valid<=1, PC<=PC+PC_STEP.
REQ-010 stall=1 (no redirect): PC and all if_id_* outputs SHALL hold.
REQ-011 redirect=1: PC<=redirect_pc, if_id_valid<=0 next cycle; redirect SHALL win over simultaneous stall.
REQ-012 PC and if_id_pcpp arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-013 stall and redirect SHALL be ignored outside ST_RUN.

Reset
REQ-014 On reset: FSM=ST_BOOT, load counter=0, PC=RESET_PC, if_id_valid=0, if_id_instr=0, if_id_pcpp=0, boot_error=0, checksum accumulator=0. During the reset cycle imem_we=0 and boot_ready=0.
REQ-015 Reset asserted in any state, including mid-load, SHALL abort the operation; reload restarts at word 0.

Configuration
REQ-016 Macro BOOT_CHECKSUM_EN: when defined, accumulate sum of accepted boot words modulo 2^DATA_W; on the final handshake, compare the sum including the final word with boot_checksum. Match -> ST_RUN. Mismatch -> ST_ERROR: boot_error=1, boot_ready=0, imem_we=0, imem_oe=0, on_bios=0, if_id_valid=0, held until reset.
REQ-017 Without BOOT_CHECKSUM_EN: no accumulator, ST_ERROR unreachable, boot_error tied 0, boot_checksum ignored.

Structure
REQ-018 Shared package boot_fetch_pkg SHALL hold the state enum (ST_BOOT, ST_RUN, ST_ERROR) and default width constants (DATA_W=32, ADDR_W=32).
REQ-019 PC register with stall/redirect/increment logic SHALL be sub-module fetch_pc; FSM, loader and IF/ID register stay in boot_fetch_unit.

Verification (BOOT_WORDS=4, RESET_PC=0, PC_STEP=1)
REQ-020 Boot 0x11,0x22,0x33,0x44 with boot_valid held high -> imem_we on 4 consecutive cycles at addr 0..3; ST_RUN on the next edge; on_bios falls.
REQ-021 Boot with boot_valid gaps (1 idle cycle between each word) -> exactly 4 writes at addr 0..3, no write on idle cycles.
REQ-022 After boot, run 5 cycles -> if_id_instr 0x11,0x22,0x33,0x44 with if_id_pcpp 1,2,3,4, valid from the 2nd ST_RUN cycle.
REQ-023 stall for 2 cycles at PC=2, then redirect=1 with stall=1 and redirect_pc=0 -> outputs hold 2 cycles; next cycle if_id_valid=0, PC=0; following cycle if_id_instr=0x11.
REQ-024 Reset asserted after 2 of 4 boot words -> counter=0; full reload writes addr 0..3 again.
REQ-025 With BOOT_CHECKSUM_EN: boot_checksum=0xAA -> ST_RUN; boot_checksum=0xAB -> boot_error=1, imem_oe=0, if_id_valid stays 0.
